// File: rtl/bus_transfer_sequencer.sv
// Round-robin sequencer for register-to-register moves on the shared data bus.
// Drives the per-register OE/WE strobes so only one register ever drives the bus.
module bus_transfer_sequencer #(
    parameter int NREQ = 2,
    parameter int NREG = 4,
    parameter int SELW = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SELW-1:0]   src_sel,
    input  logic [NREQ*SELW-1:0]   dst_sel,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic [NREG-1:0]        oe,
    output logic [NREG-1:0]        we,
    output logic                   busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, DRIVE, LATCH, DONE, ERR} state_t;

    state_t                     state;
    logic [PW-1:0]              ptr, win, pick;
    logic [SELW-1:0]            src, dst, pick_src, pick_dst;
    logic                       pick_bad;
    logic [NREQ-1:0][SELW-1:0]  src_v, dst_v;

    assign src_v = src_sel;
    assign dst_v = dst_sel;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
        return (int'(x) >= NREQ - 1) ? '0 : x + 1'b1;
    endfunction

    // Search upward from ptr with wrap; the lowest offset with a request wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] ci;
        idx  = 0;
        ci   = '0;
        pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            ci = PW'(idx);
            if (req[ci]) pick = ci;
        end
        pick_src = src_v[pick];
        pick_dst = dst_v[pick];
        pick_bad = (pick_src == pick_dst) || (int'(pick_src) >= NREG) ||
                   (int'(pick_dst) >= NREG);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            src   <= '0;
            dst   <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    win <= pick;
                    src <= pick_src;
                    dst <= pick_dst;
                    if (pick_bad) begin
                        state <= ERR;
                        ptr   <= inc(pick);
                    end else begin
                        state <= DRIVE;
                    end
                end
                DRIVE: state <= LATCH;
                LATCH: begin
                    state <= DONE;
                    ptr   <= inc(win);
                end
                DONE, ERR: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    always_comb begin
        grant = '0;
        done  = '0;
        err   = '0;
        oe    = '0;
        we    = '0;
        if (state != IDLE) grant[win] = 1'b1;
        if (state == DONE) done[win]  = 1'b1;
        if (state == ERR)  err[win]   = 1'b1;
        for (int j = 0; j < NREG; j++) begin
            if ((state == DRIVE || state == LATCH) && src == SELW'(j)) oe[j] = 1'b1;
            if (state == LATCH && dst == SELW'(j)) we[j] = 1'b1;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: directed sequences on a 2x4 instance, an
// out-of-range case on a 2x3 instance, and random traffic on a 4x8 instance.
module tb_bus_transfer_sequencer;
    logic CLK = 0;
    logic RESET = 0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {int who; bit is_err; int cyc;} exp_t;
    exp_t qa[$];
    exp_t qb[$];

    logic [1:0] a_req, a_grant, a_done, a_err;
    logic [3:0] a_src, a_dst, a_oe, a_we;
    logic       a_busy;
    logic [3:0] b_req, b_grant, b_done, b_err;
    logic [15:0] b_src, b_dst;
    logic [7:0] b_oe, b_we;
    logic       b_busy;
    logic [1:0] c_req, c_grant, c_done, c_err;
    logic [3:0] c_src, c_dst;
    logic [2:0] c_oe, c_we;
    logic       c_busy;

    bus_transfer_sequencer #(.NREQ(2), .NREG(4), .SELW(2)) dut_a (
        .CLK(CLK), .RESET(RESET), .req(a_req), .src_sel(a_src), .dst_sel(a_dst),
        .grant(a_grant), .done(a_done), .err(a_err), .oe(a_oe), .we(a_we), .busy(a_busy));
    bus_transfer_sequencer #(.NREQ(4), .NREG(8), .SELW(4)) dut_b (
        .CLK(CLK), .RESET(RESET), .req(b_req), .src_sel(b_src), .dst_sel(b_dst),
        .grant(b_grant), .done(b_done), .err(b_err), .oe(b_oe), .we(b_we), .busy(b_busy));
    bus_transfer_sequencer #(.NREQ(2), .NREG(3), .SELW(2)) dut_c (
        .CLK(CLK), .RESET(RESET), .req(c_req), .src_sel(c_src), .dst_sel(c_dst),
        .grant(c_grant), .done(c_done), .err(c_err), .oe(c_oe), .we(c_we), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus-attached registers behind dut_a, moved by its strobes.
    logic [7:0] regs [4] = '{8'h11, 8'hA5, 8'h33, 8'h44};
    always @(posedge CLK) begin
        logic [7:0] bus;
        bus = '0;
        for (int j = 0; j < 4; j++) if (a_oe[j]) bus = regs[j];
        if (RESET) for (int j = 0; j < 4; j++) if (a_we[j]) regs[j] <= bus;
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RESET && (a_done | a_err) != 0) begin
            if (qa.size() == 0) chk("a_unexp", {a_done, a_err}, 0);
            else begin
                e = qa.pop_front();
                chk("a_who", a_done | a_err, 32'(1) << e.who);
                chk("a_kind", a_err != 0, e.is_err);
                chk("a_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic push_a(input int who, input bit is_err, input int at);
        qa.push_back('{who, is_err, at});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
    endtask

    logic [3:0] fired;
    logic [7:0] prev_oe = '0;

    task automatic b_collect();
        int k;
        fired = '0;
        for (int i = 0; i < 4; i++) begin
            if (b_done[i] | b_err[i]) begin
                k = -1;
                foreach (qb[j]) if (qb[j].who == i && k < 0) k = j;
                if (k < 0) chk("b_unexp", 1, 0);
                else begin
                    chk("b_kind", b_err[i], qb[k].is_err);
                    chk("b_grant", b_grant, 32'(1) << i);
                    qb.delete(k);
                end
                b_req[i] = 1'b0;
                fired[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int c, c2, n, s, d;
        a_req = '0; a_src = '0; a_dst = '0;
        b_req = '0; b_src = '0; b_dst = '0;
        c_req = '0; c_src = '0; c_dst = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_oe", a_oe, 0); chk("rst_grant", a_grant, 0); chk("rst_busy", a_busy, 0);
        RESET = 1;
        @(negedge CLK);

        // single transfer 1 -> 0
        c = cyc; a_src = {2'd0, 2'd1}; a_dst = {2'd0, 2'd0}; a_req = 2'b01;
        push_a(0, 0, c + 3);
        @(negedge CLK);
        chk("t1_oe_c1", a_oe, 4'b0010); chk("t1_we_c1", a_we, 0);
        chk("t1_busy_c1", a_busy, 1); chk("t1_grant", a_grant, 2'b01);
        @(negedge CLK);
        chk("t1_oe_c2", a_oe, 4'b0010); chk("t1_we_c2", a_we, 4'b0001);
        @(negedge CLK);
        chk("t1_done", a_done, 2'b01); chk("t1_oe_c3", a_oe, 0); chk("t1_we_c3", a_we, 0);
        chk("t1_busy_c3", a_busy, 1); chk("t1_reg0", regs[0], 8'hA5);
        a_req = 2'b00;
        @(negedge CLK);
        chk("t1_idle", a_busy, 0);

        // contention from reset: 0,1,0,1
        do_reset();
        c = cyc; a_src = {2'd2, 2'd1}; a_dst = {2'd3, 2'd0}; a_req = 2'b11;
        push_a(0, 0, c + 3); push_a(1, 0, c + 7); push_a(0, 0, c + 11); push_a(1, 0, c + 15);
        @(negedge CLK);     chk("t2_g0", a_grant, 2'b01);
        repeat (4) @(negedge CLK); chk("t2_g1", a_grant, 2'b10);
        repeat (4) @(negedge CLK); chk("t2_g2", a_grant, 2'b01);
        repeat (4) @(negedge CLK); chk("t2_g3", a_grant, 2'b10);
        repeat (2) @(negedge CLK); a_req = 2'b00;
        repeat (2) @(negedge CLK);
        chk("t2_idle", a_busy, 0); chk("t2_reg3", regs[3], 8'h33);

        // illegal requests, pointer advance
        c = cyc; a_src = {2'd0, 2'd2}; a_dst = {2'd0, 2'd2}; a_req = 2'b01;
        c_src = {2'd0, 2'd3}; c_dst = {2'd0, 2'd0}; c_req = 2'b01;
        push_a(0, 1, c + 1);
        @(negedge CLK);
        chk("t3_err", a_err, 2'b01); chk("t3_oe", a_oe, 0); chk("t3_we", a_we, 0);
        chk("t3_grant", a_grant, 2'b01);
        chk("t3_c_err", c_err, 2'b01); chk("t3_c_oe", c_oe, 0); chk("t3_c_we", c_we, 0);
        a_req = 2'b00; c_req = 2'b00;
        @(negedge CLK);
        chk("t3_oe_after", a_oe, 0); chk("t3_we_after", a_we, 0);
        c2 = cyc; a_src = {2'd2, 2'd1}; a_dst = {2'd3, 2'd0}; a_req = 2'b11;
        c_src = {2'd0, 2'd2}; c_dst = {2'd0, 2'd1}; c_req = 2'b01;
        push_a(1, 0, c2 + 3); push_a(0, 0, c2 + 7);
        @(negedge CLK);
        chk("t3_ptr", a_grant, 2'b10); chk("t3_c_oe_ok", c_oe, 3'b100);
        @(negedge CLK);
        chk("t3_c_we_ok", c_we, 3'b010);
        @(negedge CLK);
        chk("t3_c_done", c_done, 2'b01);
        a_req = 2'b01; c_req = 2'b00;
        repeat (4) @(negedge CLK); a_req = 2'b00;
        repeat (2) @(negedge CLK);

        // reset in LATCH, between edges
        a_src = {2'd0, 2'd1}; a_dst = {2'd0, 2'd2}; a_req = 2'b01;
        repeat (2) @(negedge CLK);
        chk("t4_oe_latch", a_oe, 4'b0010); chk("t4_we_latch", a_we, 4'b0100);
        #2 RESET = 0;
        #1;
        chk("t4_oe_rst", a_oe, 0); chk("t4_we_rst", a_we, 0);
        chk("t4_grant_rst", a_grant, 0); chk("t4_busy_rst", a_busy, 0);
        a_req = 2'b00;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1;
        chk("t4_reg2", regs[2], 8'h33);
        @(negedge CLK);
        c = cyc; a_src = {2'd2, 2'd1}; a_dst = {2'd3, 2'd0}; a_req = 2'b11;
        push_a(0, 0, c + 3); push_a(1, 0, c + 7);
        @(negedge CLK);
        chk("t4_ptr0", a_grant, 2'b01);
        repeat (2) @(negedge CLK); a_req = 2'b10;
        repeat (4) @(negedge CLK); a_req = 2'b00;
        repeat (2) @(negedge CLK);

        // held request gives a second transfer 4 cycles later
        c = cyc; a_src = {2'd0, 2'd3}; a_dst = {2'd0, 2'd1}; a_req = 2'b01;
        push_a(0, 0, c + 3); push_a(0, 0, c + 7);
        repeat (5) @(negedge CLK);
        chk("t5_second", a_grant, 2'b01); chk("t5_oe", a_oe, 4'b1000);
        repeat (2) @(negedge CLK); a_req = 2'b00;
        repeat (2) @(negedge CLK);
        chk("a_drain", qa.size(), 0);

        // random traffic with bus invariants
        for (int t = 0; t < 2000; t++) begin
            @(negedge CLK);
            chk("b_oe_1hot", $countones(b_oe) <= 1, 1);
            chk("b_we_1hot", $countones(b_we) <= 1, 1);
            chk("b_oe_pulse", (b_oe != 0) && ((b_done | b_err) != 0), 0);
            chk("b_oe_we", b_oe & b_we, 0);
            if (b_we != 0) chk("b_we_prior", (prev_oe == b_oe) && (b_oe != 0), 1);
            prev_oe = b_oe;
            b_collect();
            for (int i = 0; i < 4; i++) begin
                if (!b_req[i] && !fired[i] && $urandom_range(3) == 0) begin
                    s = $urandom_range(9);
                    d = ($urandom_range(7) == 0) ? s : $urandom_range(9);
                    b_src[i*4 +: 4] = 4'(s);
                    b_dst[i*4 +: 4] = 4'(d);
                    b_req[i] = 1'b1;
                    qb.push_back('{i, (s == d) || (s >= 8) || (d >= 8), 0});
                end
            end
        end
        n = 0;
        while (qb.size() != 0 && n < 200) begin
            @(negedge CLK);
            b_collect();
            n++;
        end
        chk("b_drain", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
